bk_kbd_mpi: RTL and testbench

- Keyboard controller acting as a synchronous MPI-bus responder for the K1801VM1 bus initiator.
- Decodes the register pair 177660 (status) and 177662 (data).
- Answers DIN/DOUT with nRPLY and raises a vectored interrupt via nVIRQ.
- Returns the interrupt vector during the IAKO acknowledge cycle.
- Sits on the shared inverted AD bus beside ROM, DRAM controller and port registers; the top level ties the tristate.

---
 rtl/bk_kbd_mpi.sv | 151 +++++++++++++++
 tb/tb_bk_kbd_mpi.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/bk_kbd_mpi.sv
// Keyboard controller for the K1801VM1 MPI bus: status/data register pair,
// a reply FSM for DIN/DOUT, and a vectored interrupt acknowledged through IAKO.
module bk_kbd_mpi #(
  parameter logic [15:0] BASE_ADDR = 16'o177660,
  parameter logic [15:0] VEC_MAIN  = 16'o000060,
  parameter logic [15:0] VEC_AR2   = 16'o000274
) (
  input  logic        pin_clk,
  input  logic        pin_rst,
  input  logic [15:0] pin_ad_n,
  output logic [15:0] pin_ad_out_n,
  output logic        pin_ad_oe,
  input  logic        pin_sync_n,
  input  logic        pin_din_n,
  input  logic        pin_dout_n,
  input  logic        pin_wtbt_n,
  input  logic        pin_iako_n,
  output logic        pin_rply_n,
  output logic        pin_virq_n,
  input  logic        key_stb,
  input  logic [6:0]  key_code,
  input  logic        key_ar2,
  output logic        key_ack
);

  typedef enum logic [2:0] {IDLE, SEL, RD, WR, HOLD, IAK, SKIP} state_t;

  state_t      state;
  logic        is_data;
  logic        is_odd;
  logic        ready;
  logic        mask;
  logic [6:0]  code;
  logic        ar2;
  logic        irq_taken;

  logic [15:0] ad_in;
  logic        hit_stat;
  logic        hit_data;
  logic        data_rd;
  logic        key_load;
  logic [15:0] stat_val;
  logic [15:0] data_val;

  // Address decode and read values, all from current register state
  always_comb begin
    ad_in    = ~pin_ad_n;
    hit_stat = (ad_in[15:1] == BASE_ADDR[15:1]);
    hit_data = (ad_in[15:1] == (BASE_ADDR[15:1] + 15'd1));
    data_rd  = (state == SEL) && !pin_sync_n && !pin_din_n && is_data;
    // A data read frees the buffer on the same edge, so a coincident key is not lost
    key_load = key_stb && (!ready || data_rd);
    stat_val = {8'b0, ready, mask, 6'b0};
    data_val = {9'b0, code};
  end

  always_ff @(posedge pin_clk or posedge pin_rst) begin
    if (pin_rst) begin
      state        <= IDLE;
      is_data      <= 1'b0;
      is_odd       <= 1'b0;
      ready        <= 1'b0;
      mask         <= 1'b0;
      code         <= 7'd0;
      ar2          <= 1'b0;
      irq_taken    <= 1'b0;
      pin_rply_n   <= 1'b1;
      pin_virq_n   <= 1'b1;
      pin_ad_oe    <= 1'b0;
      pin_ad_out_n <= 16'hFFFF;
      key_ack      <= 1'b0;
    end else begin
      key_ack    <= 1'b0;
      pin_virq_n <= !(ready && !mask && !irq_taken);

      if (key_load) begin
        code      <= key_code;
        ar2       <= key_ar2;
        ready     <= 1'b1;
        key_ack   <= 1'b1;
        irq_taken <= 1'b0;
      end else if (data_rd) begin
        ready     <= 1'b0;
        irq_taken <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (!pin_sync_n) begin
            is_data <= hit_data;
            is_odd  <= ad_in[0];
            state   <= (hit_stat || hit_data) ? SEL : SKIP;
          end else if (!pin_din_n && !pin_iako_n && !pin_virq_n) begin
            pin_ad_out_n <= ~(ar2 ? VEC_AR2 : VEC_MAIN);
            pin_ad_oe    <= 1'b1;
            pin_rply_n   <= 1'b0;
            pin_virq_n   <= 1'b1;
            irq_taken    <= 1'b1;
            state        <= IAK;
          end
        end
        SEL: begin
          if (pin_sync_n) begin
            state <= IDLE;
          end else if (!pin_din_n) begin
            pin_ad_out_n <= ~(is_data ? data_val : stat_val);
            pin_ad_oe    <= 1'b1;
            pin_rply_n   <= 1'b0;
            state        <= RD;
          end else if (!pin_dout_n) begin
            pin_rply_n <= 1'b0;
            // Odd-byte writes to the status register do not touch the low byte
            if (!is_data && !(!pin_wtbt_n && is_odd)) mask <= ad_in[6];
            state <= WR;
          end
        end
        RD, WR: begin
          if (pin_sync_n) begin
            pin_rply_n   <= 1'b1;
            pin_ad_oe    <= 1'b0;
            pin_ad_out_n <= 16'hFFFF;
            state        <= IDLE;
          end else begin
            state <= HOLD;
          end
        end
        HOLD: begin
          if (pin_din_n && pin_dout_n) begin
            pin_rply_n   <= 1'b1;
            pin_ad_oe    <= 1'b0;
            pin_ad_out_n <= 16'hFFFF;
            state        <= SEL;
          end
        end
        IAK: begin
          if (pin_din_n) begin
            pin_rply_n   <= 1'b1;
            pin_ad_oe    <= 1'b0;
            pin_ad_out_n <= 16'hFFFF;
            state        <= IDLE;
          end
        end
        SKIP: begin
          if (pin_sync_n) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bk_kbd_mpi.sv
// Scoreboard bench for bk_kbd_mpi: bus tasks push expected read data, a
// monitor pops and compares on every data-driving reply.
module tb_bk_kbd_mpi;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ad_n = 16'hFFFF;
  logic [15:0] ad_out_n;
  logic        ad_oe;
  logic        sync_n = 1'b1;
  logic        din_n = 1'b1;
  logic        dout_n = 1'b1;
  logic        wtbt_n = 1'b1;
  logic        iako_n = 1'b1;
  logic        rply_n;
  logic        virq_n;
  logic        kstb = 1'b0;
  logic [6:0]  kcode = 7'd0;
  logic        kar2 = 1'b0;
  logic        kack;

  int compared = 0;
  int mismatched = 0;
  logic [15:0] sb_q[$];
  logic        prev_rply = 1'b1;

  bk_kbd_mpi dut (
    .pin_clk(clk), .pin_rst(rst), .pin_ad_n(ad_n), .pin_ad_out_n(ad_out_n),
    .pin_ad_oe(ad_oe), .pin_sync_n(sync_n), .pin_din_n(din_n), .pin_dout_n(dout_n),
    .pin_wtbt_n(wtbt_n), .pin_iako_n(iako_n), .pin_rply_n(rply_n), .pin_virq_n(virq_n),
    .key_stb(kstb), .key_code(kcode), .key_ar2(kar2), .key_ack(kack)
  );

  always #5 clk = ~clk;

  // Monitor: a falling reply with the bus driven is a read or vector response
  always @(negedge clk) begin
    if (prev_rply === 1'b1 && rply_n === 1'b0 && ad_oe === 1'b1) begin
      compared++;
      if (sb_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_read: got %o, scoreboard empty", ~ad_out_n);
      end else begin
        logic [15:0] e;
        e = sb_q.pop_front();
        if (~ad_out_n !== e) begin
          mismatched++;
          $display("FAIL read_data: got %o, expected %o", ~ad_out_n, e);
        end
      end
    end
    prev_rply = rply_n;
  end

  task automatic check(input string nm, input logic [15:0] got, input logic [15:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %o, expected %o", nm, got, exp);
    end
  endtask

  task automatic wait_rply(input logic lvl, input string nm);
    int n = 0;
    while (rply_n !== lvl && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(nm, 16'(rply_n), 16'(lvl));
  endtask

  task automatic bus_read(input logic [15:0] a, input logic [15:0] exp,
                          input logic with_key, input logic [6:0] kc);
    @(posedge clk); #1;
    ad_n = ~a; sync_n = 1'b0; wtbt_n = 1'b1;
    @(posedge clk); #1;
    ad_n = 16'hFFFF; din_n = 1'b0;
    sb_q.push_back(exp);
    if (with_key) begin kstb = 1'b1; kcode = kc; kar2 = 1'b0; end
    @(negedge clk);
    check("rply_early", 16'(rply_n), 16'd1);
    @(posedge clk); #1;
    check("rply_latency", 16'(rply_n), 16'd0);
    if (with_key) begin
      kstb = 1'b0;
      check("ack_coincident", 16'(kack), 16'd1);
    end
    @(negedge clk);
    din_n = 1'b1;
    wait_rply(1'b1, "rply_release_rd");
    @(posedge clk); #1;
    sync_n = 1'b1;
    @(posedge clk);
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [15:0] d, input logic byte_wr);
    @(posedge clk); #1;
    ad_n = ~a; sync_n = 1'b0; wtbt_n = 1'b0;
    @(posedge clk); #1;
    ad_n = ~d; wtbt_n = byte_wr ? 1'b0 : 1'b1; dout_n = 1'b0;
    wait_rply(1'b0, "rply_wr");
    dout_n = 1'b1;
    wait_rply(1'b1, "rply_release_wr");
    @(posedge clk); #1;
    sync_n = 1'b1; wtbt_n = 1'b1; ad_n = 16'hFFFF;
    @(posedge clk);
  endtask

  task automatic iak(input logic [15:0] exp);
    @(posedge clk); #1;
    iako_n = 1'b0; din_n = 1'b0;
    sb_q.push_back(exp);
    wait_rply(1'b0, "rply_iak");
    din_n = 1'b1; iako_n = 1'b1;
    wait_rply(1'b1, "rply_release_iak");
    @(posedge clk); #1;
    check("virq_after_iak", 16'(virq_n), 16'd1);
  endtask

  task automatic send_key(input logic [6:0] c, input logic a2, input logic exp_ack);
    @(posedge clk); #1;
    kstb = 1'b1; kcode = c; kar2 = a2;
    @(posedge clk); #1;
    kstb = 1'b0;
    check("key_ack", 16'(kack), 16'(exp_ack));
    @(posedge clk); #1;
    check("key_ack_pulse", 16'(kack), 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_rply", 16'(rply_n), 16'd1);
    check("rst_virq", 16'(virq_n), 16'd1);
    check("rst_oe", 16'(ad_oe), 16'd0);
    check("rst_ad_out", ad_out_n, 16'hFFFF);
    check("rst_ack", 16'(kack), 16'd0);
    rst = 1'b0;

    bus_read(16'o177660, 16'o000000, 1'b0, 7'd0);

    // Normal key, interrupt and acknowledge
    send_key(7'o101, 1'b0, 1'b1);
    check("virq_key1", 16'(virq_n), 16'd0);
    bus_read(16'o177660, 16'o000200, 1'b0, 7'd0);
    iak(16'o000060);
    repeat (3) @(posedge clk);
    #1 check("virq_taken_stays", 16'(virq_n), 16'd1);
    bus_read(16'o177662, 16'o000101, 1'b0, 7'd0);
    bus_read(16'o177660, 16'o000000, 1'b0, 7'd0);

    // AR2 key vector
    send_key(7'o040, 1'b1, 1'b1);
    check("virq_key2", 16'(virq_n), 16'd0);
    iak(16'o000274);
    bus_read(16'o177662, 16'o000040, 1'b0, 7'd0);
    bus_read(16'o177660, 16'o000000, 1'b0, 7'd0);

    // Mask handling
    bus_write(16'o177660, 16'o000100, 1'b0);
    bus_read(16'o177660, 16'o000100, 1'b0, 7'd0);
    send_key(7'o055, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1 check("virq_masked", 16'(virq_n), 16'd1);
    bus_read(16'o177660, 16'o000300, 1'b0, 7'd0);
    bus_write(16'o177661, 16'o000000, 1'b1);
    bus_read(16'o177660, 16'o000300, 1'b0, 7'd0);
    bus_write(16'o177660, 16'o000000, 1'b0);
    #1 check("virq_unmasked", 16'(virq_n), 16'd0);
    bus_write(16'o177662, 16'o000177, 1'b0);
    bus_read(16'o177662 - 16'd2, 16'o000200, 1'b0, 7'd0);

    // Dropped key and key coincident with data read
    send_key(7'o066, 1'b0, 1'b0);
    bus_read(16'o177662, 16'o000055, 1'b1, 7'o077);
    bus_read(16'o177660, 16'o000200, 1'b0, 7'd0);
    bus_read(16'o177662, 16'o000077, 1'b0, 7'd0);
    bus_read(16'o177660, 16'o000000, 1'b0, 7'd0);

    // Unselected address: no reply, bus never driven
    @(posedge clk); #1;
    ad_n = ~16'o177664; sync_n = 1'b0;
    @(posedge clk); #1;
    ad_n = 16'hFFFF; din_n = 1'b0;
    begin
      logic seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (rply_n !== 1'b1 || ad_oe !== 1'b0) seen = 1'b1;
      end
      check("unselected_quiet", 16'(seen), 16'd0);
    end
    din_n = 1'b1;
    @(posedge clk); #1 sync_n = 1'b1;
    @(posedge clk);

    // Reset in the middle of a read
    send_key(7'o123, 1'b0, 1'b1);
    @(posedge clk); #1;
    ad_n = ~16'o177660; sync_n = 1'b0;
    @(posedge clk); #1;
    ad_n = 16'hFFFF; din_n = 1'b0;
    sb_q.push_back(16'o000200);
    wait_rply(1'b0, "rply_before_rst");
    #2 rst = 1'b1;
    #1;
    check("rst_mid_rply", 16'(rply_n), 16'd1);
    check("rst_mid_oe", 16'(ad_oe), 16'd0);
    check("rst_mid_virq", 16'(virq_n), 16'd1);
    din_n = 1'b1; sync_n = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    bus_read(16'o177660, 16'o000000, 1'b0, 7'd0);
    bus_read(16'o177662, 16'o000000, 1'b0, 7'd0);

    repeat (2) @(posedge clk);
    check("scoreboard_drained", 16'(sb_q.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
